ov7670_stream_gen: RTL and testbench

//  Synthesizable OV7670 camera emulator: the transmit end of the camera parallel bus (PCLK/VSYNC/HREF/D[7:0]).

---
 rtl/ov7670_pkg.sv | 32 +++
 rtl/ov7670_pattern_gen.sv | 33 +++
 rtl/ov7670_stream_gen.sv | 132 +++++++++++++
 tb/tb_ov7670_stream_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared mode codes, FSM state encoding and bar colour table
package ov7670_pkg;

    typedef enum logic [1:0] {
        MODE_BARS      = 2'd0,
        MODE_RAMP      = 2'd1,
        MODE_SOLID     = 2'd2,
        MODE_SOLID_ALT = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_e;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// rtl/ov7670_pattern_gen.sv - combinational RGB565 test-pattern source
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int XW       = $clog2(H_ACTIVE),
    parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
)(
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    mode,
    input  logic [15:0]   color,
    output logic [15:0]   pix
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] addr;
    logic [2:0]  bar_idx;

    always_comb begin
        // Ramp value is the frame-buffer address, wrapped to 16 bits.
        addr    = 16'(32'(y) * 32'(H_ACTIVE) + 32'(x));
        bar_idx = 3'(32'(x) / 32'(BAR_W));
        case (mode)
            MODE_BARS: pix = bar_color(bar_idx);
            MODE_RAMP: pix = addr;
            default:   pix = color;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670 camera bus emulator emitting RGB565 QVGA frames
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
)(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iENABLE,
    input  logic [1:0]  iMODE,
    input  logic [15:0] iCOLOR,
    output logic        oPCLK,
    output logic        oVSYNC,
    output logic        oHREF,
    output logic [7:0]  oD,
    output logic        oBUSY,
    output logic        oFRAME_DONE,
    output logic [7:0]  oFRAME_CNT
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int M_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int M_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LC_MAX   = (M_A > M_B) ? M_A : M_B;
    localparam int BCW      = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 1;
    localparam int LCW      = (LC_MAX > 1) ? $clog2(LC_MAX) : 1;
    localparam int XW       = $clog2(H_ACTIVE);
    localparam int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    state_e         state;
    logic           ph;
    logic [BCW-1:0] bc;
    logic [LCW-1:0] lc;
    logic [1:0]     mode_q;
    logic [15:0]    color_q;
    logic [15:0]    pix;
    logic [LCW-1:0] phase_last;
    logic           href_now;

    assign oPCLK = ph;

    ov7670_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .x     (bc[XW:1]),
        .y     (lc[YW-1:0]),
        .mode  (mode_q),
        .color (color_q),
        .pix   (pix)
    );

    always_comb begin
        phase_last = LCW'(V_FRONT - 1);
        case (state)
            ST_VSYNC:  phase_last = LCW'(VSYNC_LINES - 1);
            ST_VBACK:  phase_last = LCW'(V_BACK - 1);
            ST_ACTIVE: phase_last = LCW'(V_ACTIVE - 1);
            default:   phase_last = LCW'(V_FRONT - 1);
        endcase
        href_now = (state == ST_ACTIVE) && (bc < BCW'(2 * H_ACTIVE));
    end

    // Counters name the byte being emitted at this byte event; outputs are
    // registered from them so they hold steady through the next PCLK rise.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= ST_IDLE;
            ph          <= 1'b0;
            bc          <= '0;
            lc          <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            oVSYNC      <= 1'b0;
            oHREF       <= 1'b0;
            oD          <= 8'h00;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oFRAME_CNT  <= 8'h00;
        end else begin
            ph          <= ~ph;
            oFRAME_DONE <= 1'b0;
            if (ph) begin
                oVSYNC <= (state == ST_VSYNC);
                oHREF  <= href_now;
                oD     <= href_now ? (bc[0] ? pix[7:0] : pix[15:8]) : 8'h00;
                oBUSY  <= (state != ST_IDLE);
                case (state)
                    ST_IDLE: begin
                        if (iENABLE) begin
                            state   <= ST_VSYNC;
                            mode_q  <= iMODE;
                            color_q <= iCOLOR;
                            bc      <= '0;
                            lc      <= '0;
                        end
                    end
                    default: begin
                        if (bc == BCW'(LINE_LEN - 1)) begin
                            bc <= '0;
                            if (lc == phase_last) begin
                                lc <= '0;
                                case (state)
                                    ST_VSYNC:  state <= ST_VBACK;
                                    ST_VBACK:  state <= ST_ACTIVE;
                                    ST_ACTIVE: state <= ST_VFRONT;
                                    default: begin
                                        state       <= iENABLE ? ST_VSYNC : ST_IDLE;
                                        oFRAME_DONE <= 1'b1;
                                        oFRAME_CNT  <= oFRAME_CNT + 8'd1;
                                    end
                                endcase
                            end else begin
                                lc <= lc + LCW'(1);
                            end
                        end else begin
                            bc <= bc + BCW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - directed checks of the OV7670 stream emulator
`timescale 1ns/1ps
module tb_ov7670_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] color = 16'h0000;
    logic        pclk, vsync, href, busy, frame_done;
    logic [7:0]  d, frame_cnt;

    logic        b_enable = 1'b0;
    logic        b_pclk, b_vsync, b_href, b_busy, b_done;
    logic [7:0]  b_d, b_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          d_leak = 0;
    logic [7:0]  lb [0:63];
    logic [7:0]  bb [0:639];
    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ov7670_stream_gen #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iENABLE(enable), .iMODE(mode), .iCOLOR(color),
        .oPCLK(pclk), .oVSYNC(vsync), .oHREF(href), .oD(d), .oBUSY(busy),
        .oFRAME_DONE(frame_done), .oFRAME_CNT(frame_cnt)
    );

    ov7670_stream_gen dut_qvga (
        .iCLK(clk), .iRST_N(rst_n), .iENABLE(b_enable), .iMODE(2'd0), .iCOLOR(16'h0000),
        .oPCLK(b_pclk), .oVSYNC(b_vsync), .oHREF(b_href), .oD(b_d), .oBUSY(b_busy),
        .oFRAME_DONE(b_done), .oFRAME_CNT(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_byte(output logic h, output logic v, output logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (pclk !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        h = href;
        v = vsync;
        b = d;
    endtask

    task automatic grab_line(output int len);
        logic h, v;
        logic [7:0] b;
        int n;
        len = 0;
        n = 0;
        get_byte(h, v, b);
        while (h !== 1'b0 && n < 2000) begin
            get_byte(h, v, b);
            n++;
        end
        while (h !== 1'b1 && n < 2000) begin
            if (b !== 8'h00) d_leak++;
            get_byte(h, v, b);
            n++;
        end
        while (h === 1'b1 && len < 64) begin
            lb[len] = b;
            len++;
            get_byte(h, v, b);
        end
        check("line_timeout", 32'(n >= 2000), 0);
    endtask

    task automatic wait_done(input int limit, output int t, output int idle);
        int n;
        n = 0;
        idle = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < limit) begin
            if (busy !== 1'b1) idle++;
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("done_timeout", 32'(n >= limit), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, t0, t1, t2, t3, idle, n, hits, vs_cyc, bad, pixv, expb;
        logic p0, p1, p2;

        // reset and idle behaviour
        repeat (3) @(negedge clk);
        check("rst_pclk", pclk, 0);
        check("rst_sync", {vsync, href, busy, frame_done}, 0);
        check("rst_data", {d, frame_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk); p0 = pclk;
        @(negedge clk); p1 = pclk;
        @(negedge clk); p2 = pclk;
        check("pclk_toggle", p1 ^ p0, 1);
        check("pclk_period", p2 ^ p0, 0);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (vsync || href || busy) hits++;
        end
        check("idle_quiet", hits, 0);

        // ramp frame
        mode = 2'd1;
        enable = 1'b1;
        n = 0;
        while (vsync !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("vs_start_timeout", 32'(n >= 100), 0);
        check("busy_in_frame", busy, 1);
        vs_cyc = 0;
        while (vsync === 1'b1 && vs_cyc < 200) begin vs_cyc++; @(negedge clk); end
        check("vsync_len", vs_cyc, 40);
        for (int y = 0; y < 4; y++) begin
            grab_line(len);
            check($sformatf("ramp_len_%0d", y), len, 16);
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                pixv = y * 8 + k / 2;
                expb = (k % 2) ? (pixv & 8'hFF) : ((pixv >> 8) & 8'hFF);
                if (lb[k] !== 8'(expb)) bad++;
            end
            check($sformatf("ramp_bytes_%0d", y), bad, 0);
            if (y == 0) begin
                check("ramp_l0_b3", lb[3], 8'h01);
                check("ramp_l0_b15", lb[15], 8'h07);
            end
            if (y == 1) check("ramp_l1_b1", lb[1], 8'h08);
        end
        hits = 0;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 200) begin
            if (href === 1'b1) hits++;
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        check("extra_href", hits, 0);
        check("done1_timeout", 32'(n >= 200), 0);
        check("cnt_1", frame_cnt, 1);
        @(negedge clk);
        check("done_width", frame_done, 0);

        // back-to-back frames
        wait_done(600, t1, idle);
        check("period_1", t1 - t0, 280);
        check("cnt_2", frame_cnt, 2);
        check("no_gap_1", idle, 0);
        wait_done(600, t2, idle);
        check("period_2", t2 - t1, 280);
        check("cnt_3", frame_cnt, 3);
        check("no_gap_2", idle, 0);

        // disable and change mode mid-frame
        grab_line(len);
        grab_line(len);
        n = 0;
        while (href !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        enable = 1'b0;
        mode = 2'd2;
        color = 16'hABCD;
        grab_line(len);
        check("late_len", len, 16);
        check("late_b0", lb[0], 8'h00);
        check("late_b1", lb[1], 8'h18);
        check("late_b15", lb[15], 8'h1F);
        wait_done(400, t3, idle);
        check("late_period", t3 - t2, 280);
        check("cnt_4", frame_cnt, 4);
        repeat (4) @(negedge clk);
        hits = 0;
        repeat (600) begin
            @(negedge clk);
            if (vsync || busy || frame_done) hits++;
        end
        check("stays_idle", hits, 0);
        check("cnt_4_hold", frame_cnt, 4);

        // colour bars, one pixel per bar at this width
        mode = 2'd0;
        enable = 1'b1;
        grab_line(len);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            expb = (k % 2) ? 32'(bars[k / 2][7:0]) : 32'(bars[k / 2][15:8]);
            if (lb[k] !== 8'(expb)) bad++;
        end
        check("bars_bytes", bad, 0);
        check("bars_b2", lb[2], 8'hFF);
        check("bars_b3", lb[3], 8'hE0);
        check("bars_b9", lb[9], 8'h1F);

        // solid colour after returning to idle
        enable = 1'b0;
        mode = 2'd2;
        color = 16'h5A3C;
        wait_done(600, t0, idle);
        check("cnt_5", frame_cnt, 5);
        repeat (8) @(negedge clk);
        check("busy_idle", busy, 0);
        enable = 1'b1;
        grab_line(len);
        bad = 0;
        for (int k = 0; k < 16; k++) if (lb[k] !== ((k % 2) ? 8'h3C : 8'h5A)) bad++;
        check("solid_bytes", bad, 0);
        check("solid_b0", lb[0], 8'h5A);

        // asynchronous reset in active line 3
        grab_line(len);
        grab_line(len);
        n = 0;
        while (href !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_href", href, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sync", {pclk, vsync, href, busy, frame_done}, 0);
        check("arst_d", d, 0);
        check("arst_cnt", frame_cnt, 0);
        repeat (3) @(negedge clk);
        mode = 2'd1;
        rst_n = 1'b1;
        hits = 0;
        n = 0;
        while (vsync !== 1'b1 && n < 100) begin
            if (href === 1'b1) hits++;
            @(negedge clk);
            n++;
        end
        check("post_rst_vs_timeout", 32'(n >= 100), 0);
        check("post_rst_no_href", hits, 0);
        check("post_rst_cnt0", frame_cnt, 0);
        wait_done(400, t0, idle);
        check("post_rst_cnt1", frame_cnt, 1);
        enable = 1'b0;
        check("blank_data_zero", d_leak, 0);

        // default geometry, colour bars
        b_enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(b_href === 1'b1 && b_pclk === 1'b1) && n < 40000) begin @(negedge clk); n++; end
        check("qvga_href_timeout", 32'(n >= 40000), 0);
        n = 0;
        for (int k = 0; k < 640 && n < 4000; ) begin
            if (b_pclk === 1'b1) begin
                bb[k] = b_d;
                k++;
            end
            @(negedge clk);
            n++;
        end
        check("qvga_x0", {bb[0], bb[1]}, 16'hFFFF);
        check("qvga_x39", {bb[78], bb[79]}, 16'hFFFF);
        check("qvga_x40", {bb[80], bb[81]}, 16'hFFE0);
        check("qvga_x120", {bb[240], bb[241]}, 16'h07E0);
        check("qvga_x319", {bb[638], bb[639]}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
